// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg -- shared types and constants for the write-back stage.
//   size_e    : load size encoding (byte / half / word / dword)
//   XZR_IDX   : zero register index, never written
//   LINK_IDX  : link register used by branch-and-link
//   PC_INC    : return-address offset for branch-and-link
//   wb_reg_t  : contents of the WB pipeline register
//   fwd_reg_t : contents of the EX bypass register
// ---------------------------------------------------------------------------
package wb_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  localparam logic [4:0]  XZR_IDX  = 5'd31;
  localparam logic [4:0]  LINK_IDX = 5'd30;
  localparam logic [63:0] PC_INC   = 64'd4;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_to_reg;
    logic        bl;
    size_e       size;
    logic [4:0]  rd;
    logic [63:0] alu;
    logic [63:0] rdata;
    logic [63:0] pc;
  } wb_reg_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [63:0] data;
  } fwd_reg_t;

endpackage

// File: rtl/data_wb_if.sv
// ---------------------------------------------------------------------------
// data_wb_if -- bundle of MEM-side inputs and regfile/bypass outputs of the
// write-back stage.
//   slave  : the stage itself (consumes stall/flush/mem_*, drives results)
//   master : the pipeline around it
// Signals:
//   stall, flush                 pipeline control
//   mem_valid, mem_RegWrite,
//   mem_MemtoReg, mem_BLsignal   MEM stage control bits
//   mem_size[1:0], mem_Rd[4:0]   load size, destination register
//   mem_alu, mem_rdata, mem_pc   64-bit MEM stage data
//   RegWrite, Rd_wb, WBsignal    regfile write port
//   fwd_valid, fwd_rd, fwd_data  EX bypass pair
//   retired[CNT_W-1:0]           retired-instruction count
// ---------------------------------------------------------------------------
interface data_wb_if #(
  parameter int unsigned CNT_W = 32
);
  logic             stall;
  logic             flush;
  logic             mem_valid;
  logic             mem_RegWrite;
  logic             mem_MemtoReg;
  logic             mem_BLsignal;
  logic [1:0]       mem_size;
  logic [4:0]       mem_Rd;
  logic [63:0]      mem_alu;
  logic [63:0]      mem_rdata;
  logic [63:0]      mem_pc;

  logic             RegWrite;
  logic [4:0]       Rd_wb;
  logic [63:0]      WBsignal;
  logic             fwd_valid;
  logic [4:0]       fwd_rd;
  logic [63:0]      fwd_data;
  logic [CNT_W-1:0] retired;

  modport slave (
    input  stall, flush, mem_valid, mem_RegWrite, mem_MemtoReg, mem_BLsignal,
           mem_size, mem_Rd, mem_alu, mem_rdata, mem_pc,
    output RegWrite, Rd_wb, WBsignal, fwd_valid, fwd_rd, fwd_data, retired
  );

  modport master (
    output stall, flush, mem_valid, mem_RegWrite, mem_MemtoReg, mem_BLsignal,
           mem_size, mem_Rd, mem_alu, mem_rdata, mem_pc,
    input  RegWrite, Rd_wb, WBsignal, fwd_valid, fwd_rd, fwd_data, retired
  );
endinterface

// File: rtl/load_extend.sv
// ---------------------------------------------------------------------------
// load_extend -- zero-extends load data to 64 bits according to load size.
//   i_size  : SZ_B / SZ_H / SZ_W / SZ_D
//   i_rdata : raw 64-bit memory read data
//   o_data  : zero-extended result
// ---------------------------------------------------------------------------
module load_extend
  import wb_pkg::*;
(
  input  size_e       i_size,
  input  logic [63:0] i_rdata,
  output logic [63:0] o_data
);

  always_comb begin
    o_data = '0;
    case (i_size)
      SZ_B:    o_data = {56'd0, i_rdata[7:0]};
      SZ_H:    o_data = {48'd0, i_rdata[15:0]};
      SZ_W:    o_data = {32'd0, i_rdata[31:0]};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/data_wb.sv
// ---------------------------------------------------------------------------
// data_wb -- pipeline write-back stage.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : data_wb_if.slave (MEM inputs, regfile write port, EX bypass,
//             retired counter)
// Holds the WB register, selects the write-back value (link / load / ALU),
// gates the regfile write, keeps a one-deep bypass register of the last
// retired result and counts retired instructions modulo 2^CNT_W.
// ---------------------------------------------------------------------------
module data_wb
  import wb_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input logic       clk,
  input logic       reset_n,
  data_wb_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  wb_reg_t          r_wb;
  fwd_reg_t         r_fwd;
  logic [CNT_W-1:0] r_retired;

  wb_reg_t          w_cap;
  logic [63:0]      w_ext;
  logic [63:0]      w_data;
  logic [4:0]       w_rd;
  logic             w_regwrite;
  logic             w_retire;

  always_comb begin
    w_cap            = '0;
    w_cap.valid      = bus.mem_valid;
    w_cap.reg_write  = bus.mem_RegWrite;
    w_cap.mem_to_reg = bus.mem_MemtoReg;
    w_cap.bl         = bus.mem_BLsignal;
    w_cap.size       = size_e'(bus.mem_size);
    w_cap.rd         = bus.mem_Rd;
    w_cap.alu        = bus.mem_alu;
    w_cap.rdata      = bus.mem_rdata;
    w_cap.pc         = bus.mem_pc;
  end

  // Flush wins over stall and loads an all-zero bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wb <= '0;
    end else if (bus.flush) begin
      r_wb <= '0;
    end else if (!bus.stall) begin
      r_wb <= w_cap;
    end
  end

  load_extend u_load_extend (
    .i_size  (r_wb.size),
    .i_rdata (r_wb.rdata),
    .o_data  (w_ext)
  );

  always_comb begin
    w_rd   = r_wb.rd;
    w_data = r_wb.alu;
    if (r_wb.bl) begin
      w_rd   = LINK_IDX;
      w_data = r_wb.pc + PC_INC;
    end else if (r_wb.mem_to_reg) begin
      w_data = w_ext;
    end
  end

  // Stall gates the write so a held entry writes exactly once, on the edge
  // where it actually retires.
  assign w_retire   = r_wb.valid & ~bus.stall;
  assign w_regwrite = w_retire & r_wb.reg_write & (w_rd != XZR_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fwd <= '0;
    end else if (w_retire) begin
      r_fwd.valid <= w_regwrite;
      r_fwd.rd    <= w_rd;
      r_fwd.data  <= w_data;
    end else if (!bus.stall) begin
      r_fwd.valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + CNT_ONE;
    end
  end

  assign bus.RegWrite  = w_regwrite;
  assign bus.Rd_wb     = w_rd;
  assign bus.WBsignal  = w_data;
  assign bus.fwd_valid = r_fwd.valid;
  assign bus.fwd_rd    = r_fwd.rd;
  assign bus.fwd_data  = r_fwd.data;
  assign bus.retired   = r_retired;

endmodule

// File: doc/data_wb.md
DATA_WB -- requirements
Module: data_wb

Interface
REQ-001 The block SHALL have the parameter CNT_W, default 32, which sets the width of the retired-instruction counter.
REQ-002 clk  in  1  Single clock; all state SHALL update on the rising edge.
REQ-003 reset_n  in  1  Reset, asynchronous and active-low.
REQ-004 stall  in  1  Hold the WB register; no retire this cycle.
REQ-005 flush  in  1  Load a bubble into the WB register.
REQ-006 mem_valid  in  1  MEM stage holds a real instruction.
REQ-007 mem_RegWrite, mem_MemtoReg, mem_BLsignal  in  1 each  Control bits from MEM.
REQ-008 mem_size  in  2  Load size: 0=byte, 1=half, 2=word, 3=dword.
REQ-009 mem_Rd  in  5  Destination register.
REQ-010 mem_alu, mem_rdata, mem_pc  in  64 each  ALU result, memory read data, instruction PC.
REQ-011 RegWrite  out  1  Regfile write enable.
REQ-012 Rd_wb  out  5  Regfile write address.
REQ-013 WBsignal  out  64  Regfile write data.
REQ-014 fwd_valid  out  1  The fwd_rd/fwd_data pair is usable for EX bypass.
REQ-015 fwd_rd  out  5  Forward address.
REQ-016 fwd_data  out  64  Forward data.
REQ-017 retired  out  CNT_W  Count of retired instructions.

Function
REQ-018 The WB register SHALL capture all mem_* inputs on a rising edge when stall=0 and flush=0.
REQ-019 When flush=1, valid SHALL be cleared on the next edge; flush SHALL take priority over stall.
REQ-020 When stall=1 and flush=0, the WB register SHALL hold its value.
REQ-021 Write-back selection: BLsignal=1 gives WBsignal=pc+4 and Rd_wb=30; otherwise MemtoReg=1 gives the extended load data; otherwise WBsignal=alu.
REQ-022 Load data SHALL be zero-extended from rdata[7:0], [15:0], [31:0], or taken in full [63:0], according to size.
REQ-023 RegWrite SHALL equal valid & reg_RegWrite & !stall & (Rd_wb != 31).
REQ-024 RegWrite and Rd_wb SHALL be combinational from the WB register, giving exactly one write per retired instruction.
REQ-025 An XZR (31) destination SHALL never produce a write.
REQ-026 An entry SHALL retire on an edge where valid=1 and stall=0; retired SHALL increment by 1 on each such edge.
REQ-027 retired SHALL wrap modulo 2^CNT_W, going from all-ones to 0.
REQ-028 The forward register SHALL load {RegWrite, Rd_wb, WBsignal} on each retiring edge.
REQ-029 The forward register SHALL clear fwd_valid on a non-retiring edge with stall=0.
REQ-030 The forward register SHALL hold its value while stall=1.
REQ-031 Latency: MEM inputs SHALL appear on RegWrite/WBsignal 1 cycle after capture, and on fwd_* 2 cycles after capture.
REQ-032 Capture of a new entry and retire of the current entry on the same edge SHALL both take effect.

Reset
REQ-033 When reset_n=0, the block SHALL immediately clear valid, all control bits, Rd, data, fwd_valid, fwd_rd, fwd_data, and retired to 0, independent of clk.
REQ-034 After reset, RegWrite=0, Rd_wb=0, WBsignal=0, and fwd_valid=0.
REQ-035 Reset asserted mid-operation SHALL discard the in-flight entry without producing a write.
REQ-036 The first capture after reset SHALL occur on the first rising edge with reset_n=1.

Structure
REQ-037 Package wb_pkg SHALL hold: the size enum (SZ_B, SZ_H, SZ_W, SZ_D), XZR_IDX=31, LINK_IDX=30, PC_INC=4, and the WB register struct typedef.
REQ-038 The block SHALL contain one combinational sub-module, load_extend, taking size and rdata and producing 64-bit data.
REQ-039 Everything else SHALL reside in data_wb.

Verification
REQ-040 Capture mem_valid=1, RegWrite=1, Rd=5, alu=0x1234 -> next cycle: RegWrite=1, Rd_wb=5, WBsignal=0x1234; the cycle after: fwd_valid=1, fwd_rd=5; retired=1.
REQ-041 Load rdata=0xFFFF_FFFF_FFFF_FF80 through each size (0..3) -> WBsignal=0x80, 0xFF80, 0xFFFF_FF80, 0xFFFF_FFFF_FFFF_FF80 respectively.
REQ-042 BL with pc=0x100, Rd=7 -> Rd_wb=30, WBsignal=0x104; Rd=31 with RegWrite=1 -> RegWrite=0, retired still increments.
REQ-043 Assert stall for 3 cycles with a valid entry -> RegWrite=0 for 3 cycles, then exactly one write; retired increases by exactly 1.
REQ-044 Assert stall=1 and flush=1 together -> valid=0 next cycle, no write; with CNT_W=4 preloaded to 15, one retire -> retired=0.
REQ-045 Assert reset_n=0 mid-cycle with a valid entry -> all outputs 0 before the next edge; no write after release until a new capture.
